// File: rtl/axil_slave.sv
// axil_slave: AXI4-Lite slave bridging single transactions onto a simple
// RIB request/acknowledge master port. One outstanding transaction at a time;
// writes win over reads when both arrive in the same idle cycle.
// Optional build macro: AXIL_SLV_TIMEOUT_EN adds a bus-wait counter that ends
// an unacknowledged RIB access after TIMEOUT_CYCLES cycles with SLVERR.
module axil_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [31:0]                   m_addr_o,
  output logic [31:0]                   m_data_o,
  output logic [3:0]                    m_sel_o,
  output logic                          m_we_o,
  output logic                          m_req_o,
  input  logic [31:0]                   m_data_i,
  input  logic                          m_ack_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_BUS  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_BUS  = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t state_r, next_state_s;

  logic                          aw_latched_r, w_latched_r;
  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_r, araddr_r;
  logic [31:0]                   wdata_r;
  logic [3:0]                    wstrb_r;

  logic awready_s, wready_s, arready_s;
  logic aw_hs_s, w_hs_s, ar_hs_s, aw_have_s, w_have_s;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
  logic [31:0] wr_data_s;
  logic [3:0]  wr_strb_s;
  logic        timeout_s;

  logic [31:0] m_addr_nxt_s, m_data_nxt_s, rdata_nxt_s;
  logic [3:0]  m_sel_nxt_s;
  logic        m_we_nxt_s, m_req_nxt_s, bvalid_nxt_s, rvalid_nxt_s;
  logic [1:0]  bresp_nxt_s, rresp_nxt_s;

  logic [31:0] m_addr_r, m_data_r, rdata_r;
  logic [3:0]  m_sel_r;
  logic        m_we_r, m_req_r, bvalid_r, rvalid_r;
  logic [1:0]  bresp_r, rresp_r;

  // Parameters and sideband inputs with no function in this bridge.
  logic unused_s;
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, C_S_AXI_DATA_WIDTH[0], TIMEOUT_CYCLES[0]};

`ifdef AXIL_SLV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_r;

  // Bus-wait counter: zero outside the bus states, counts each cycle spent waiting.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r == ST_WR_BUS || state_r == ST_RD_BUS) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= {TO_W{1'b0}};
    end
  end

  // Timeout fires on the last allowed wait cycle unless the ack arrives then.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r == ST_WR_BUS || state_r == ST_RD_BUS) && !m_ack_i && to_cnt_r == TO_LAST) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Channel readiness and handshakes; reads are only offered when no write is pending or arriving.
  always_comb begin
    awready_s = (state_r == ST_IDLE) && !aw_latched_r && !S_AXI_ARESET;
    wready_s  = (state_r == ST_IDLE) && !w_latched_r && !S_AXI_ARESET;
    arready_s = (state_r == ST_IDLE) && !aw_latched_r && !w_latched_r &&
                !S_AXI_AWVALID && !S_AXI_WVALID && !S_AXI_ARESET;
    aw_hs_s   = awready_s && S_AXI_AWVALID;
    w_hs_s    = wready_s && S_AXI_WVALID;
    ar_hs_s   = arready_s && S_AXI_ARVALID;
    aw_have_s = aw_latched_r || aw_hs_s;
    w_have_s  = w_latched_r || w_hs_s;
    wr_addr_s = aw_latched_r ? awaddr_r : S_AXI_AWADDR;
    wr_data_s = w_latched_r ? wdata_r : S_AXI_WDATA;
    wr_strb_s = w_latched_r ? wstrb_r : S_AXI_WSTRB;
    rd_addr_s = (state_r == ST_RD_BUS) ? araddr_r : S_AXI_ARADDR;
  end

  // State register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (aw_have_s && w_have_s) begin
          next_state_s = ST_WR_BUS;
        end else if (ar_hs_s) begin
          next_state_s = ST_RD_BUS;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WR_BUS: begin
        if (m_ack_i || timeout_s) next_state_s = ST_WR_RESP;
        else                      next_state_s = ST_WR_BUS;
      end
      ST_WR_RESP: begin
        if (S_AXI_BREADY) next_state_s = ST_IDLE;
        else              next_state_s = ST_WR_RESP;
      end
      ST_RD_BUS: begin
        if (m_ack_i || timeout_s) next_state_s = ST_RD_RESP;
        else                      next_state_s = ST_RD_BUS;
      end
      ST_RD_RESP: begin
        if (S_AXI_RREADY) next_state_s = ST_IDLE;
        else              next_state_s = ST_RD_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Next values of all registered outputs, derived from the upcoming state.
  always_comb begin
    m_req_nxt_s  = 1'b0;
    m_we_nxt_s   = 1'b0;
    m_addr_nxt_s = 32'h0000_0000;
    m_data_nxt_s = 32'h0000_0000;
    m_sel_nxt_s  = 4'h0;
    bvalid_nxt_s = (next_state_s == ST_WR_RESP);
    rvalid_nxt_s = (next_state_s == ST_RD_RESP);
    bresp_nxt_s  = RESP_OKAY;
    rresp_nxt_s  = RESP_OKAY;
    rdata_nxt_s  = 32'h0000_0000;
    case (next_state_s)
      ST_WR_BUS: begin
        m_req_nxt_s  = 1'b1;
        m_we_nxt_s   = 1'b1;
        m_addr_nxt_s = 32'(wr_addr_s);
        m_data_nxt_s = wr_data_s;
        m_sel_nxt_s  = wr_strb_s;
      end
      ST_RD_BUS: begin
        m_req_nxt_s  = 1'b1;
        m_addr_nxt_s = 32'(rd_addr_s);
        m_sel_nxt_s  = 4'hF;
      end
      ST_WR_RESP: begin
        if (state_r == ST_WR_BUS) begin
          bresp_nxt_s = m_ack_i ? RESP_OKAY : RESP_SLVERR;
        end else begin
          bresp_nxt_s = bresp_r;
        end
      end
      ST_RD_RESP: begin
        if (state_r == ST_RD_BUS) begin
          rresp_nxt_s = m_ack_i ? RESP_OKAY : RESP_SLVERR;
          rdata_nxt_s = m_ack_i ? m_data_i : 32'h0000_0000;
        end else begin
          rresp_nxt_s = rresp_r;
          rdata_nxt_s = rdata_r;
        end
      end
      default: begin
        m_req_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      m_req_r  <= 1'b0;
      m_we_r   <= 1'b0;
      m_addr_r <= 32'h0000_0000;
      m_data_r <= 32'h0000_0000;
      m_sel_r  <= 4'h0;
      bvalid_r <= 1'b0;
      rvalid_r <= 1'b0;
      bresp_r  <= 2'b00;
      rresp_r  <= 2'b00;
      rdata_r  <= 32'h0000_0000;
    end else begin
      m_req_r  <= m_req_nxt_s;
      m_we_r   <= m_we_nxt_s;
      m_addr_r <= m_addr_nxt_s;
      m_data_r <= m_data_nxt_s;
      m_sel_r  <= m_sel_nxt_s;
      bvalid_r <= bvalid_nxt_s;
      rvalid_r <= rvalid_nxt_s;
      bresp_r  <= bresp_nxt_s;
      rresp_r  <= rresp_nxt_s;
      rdata_r  <= rdata_nxt_s;
    end
  end

  // Write-address/data and read-address holding registers; write latches clear when the response is taken.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_latched_r <= 1'b0;
      w_latched_r  <= 1'b0;
      awaddr_r     <= {C_S_AXI_ADDR_WIDTH{1'b0}};
      araddr_r     <= {C_S_AXI_ADDR_WIDTH{1'b0}};
      wdata_r      <= 32'h0000_0000;
      wstrb_r      <= 4'h0;
    end else begin
      if (aw_hs_s) begin
        aw_latched_r <= 1'b1;
        awaddr_r     <= S_AXI_AWADDR;
      end else if (state_r == ST_WR_RESP && S_AXI_BREADY) begin
        aw_latched_r <= 1'b0;
      end
      if (w_hs_s) begin
        w_latched_r <= 1'b1;
        wdata_r     <= S_AXI_WDATA;
        wstrb_r     <= S_AXI_WSTRB;
      end else if (state_r == ST_WR_RESP && S_AXI_BREADY) begin
        w_latched_r <= 1'b0;
      end
      if (ar_hs_s) begin
        araddr_r <= S_AXI_ARADDR;
      end
    end
  end

  assign S_AXI_AWREADY = awready_s;
  assign S_AXI_WREADY  = wready_s;
  assign S_AXI_ARREADY = arready_s;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;
  assign m_req_o       = m_req_r;
  assign m_we_o        = m_we_r;
  assign m_addr_o      = m_addr_r;
  assign m_data_o      = m_data_r;
  assign m_sel_o       = m_sel_r;

endmodule

// File: tb/tb_axil_slave.sv
// tb_axil_slave: directed bench for axil_slave. Inputs change 1 time unit
// after a rising edge; outputs are sampled there too (after settling).
// Built with AXIL_SLV_TIMEOUT_EN the timeout scenario expects SLVERR.
module tb_axil_slave;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] awaddr = 32'h0, araddr = 32'h0, wdata = 32'h0;
  logic [2:0]  awprot = 3'b000, arprot = 3'b000;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic        bready = 1'b0, rready = 1'b0;
  logic [31:0] m_data_i = 32'h0;
  logic        m_ack_i = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, m_addr_o, m_data_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_req_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_slave #(
    .C_S_AXI_ADDR_WIDTH(32),
    .C_S_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_sel_o(m_sel_o), .m_we_o(m_we_o), .m_req_o(m_req_o),
    .m_data_i(m_data_i), .m_ack_i(m_ack_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Concatenation of every DUT output, used for all-zero checks.
  function automatic logic [114:0] all_outs();
    return {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
            m_addr_o, m_data_o, m_sel_o, m_we_o, m_req_o};
  endfunction

  task automatic test_reset();
    areset = 1'b1;
    tick();
    checks++;
    if (all_outs() !== 115'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", all_outs());
    end
    areset = 1'b0;
    #1;
    checks++;
    if ({awready, wready, arready, m_req_o, bvalid, rvalid} !== 6'b111000) begin
      errors++; $display("FAIL idle_ready got %b exp 111000", {awready, wready, arready, m_req_o, bvalid, rvalid});
    end
  endtask

  task automatic test_write_simultaneous();
    m_ack_i = 1'b1;
    awaddr = 32'h1000_0004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b110) begin
      errors++; $display("FAIL wr_sim_ready got %b exp 110", {awready, wready, arready});
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({m_req_o, m_we_o, m_addr_o, m_data_o, m_sel_o, bvalid} !== {2'b11, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0}) begin
      errors++; $display("FAIL wr_sim_bus got %b %b %h %h %h %b exp 1 1 10000004 deadbeef f 0",
                         m_req_o, m_we_o, m_addr_o, m_data_o, m_sel_o, bvalid);
    end
    tick();
    checks++;
    if ({bvalid, bresp, m_req_o} !== 4'b1000) begin
      errors++; $display("FAIL wr_sim_bresp got %b exp 1000", {bvalid, bresp, m_req_o});
    end
    tick();
    checks++;
    if (bvalid !== 1'b1) begin
      errors++; $display("FAIL wr_sim_bhold got %b exp 1", bvalid);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++; $display("FAIL wr_sim_done got %b exp 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_w_before_aw();
    m_ack_i = 1'b1;
    wdata = 32'hA5A5_0001; wstrb = 4'b0011; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checks++;
    if ({wready, awready, arready, m_req_o} !== 4'b0100) begin
      errors++; $display("FAIL w_first_latched got %b exp 0100", {wready, awready, arready, m_req_o});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({m_req_o, bvalid} !== 2'b00) begin
        errors++; $display("FAIL w_first_noreq cycle %0d got %b exp 00", i, {m_req_o, bvalid});
      end
    end
    awaddr = 32'h3000_0010; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checks++;
    if ({m_req_o, m_we_o, m_addr_o, m_data_o, m_sel_o} !== {2'b11, 32'h3000_0010, 32'hA5A5_0001, 4'b0011}) begin
      errors++; $display("FAIL w_first_bus got %b %b %h %h %b exp 1 1 30000010 a5a50001 0011",
                         m_req_o, m_we_o, m_addr_o, m_data_o, m_sel_o);
    end
    tick();
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin
      errors++; $display("FAIL w_first_bresp got %b exp 100", {bvalid, bresp});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bvalid, m_req_o} !== 2'b00) begin
        errors++; $display("FAIL w_first_single cycle %0d got %b exp 00", i, {bvalid, m_req_o});
      end
      tick();
    end
  endtask

  task automatic test_read_wait();
    m_ack_i = 1'b0;
    araddr = 32'h2000_0000; arvalid = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      errors++; $display("FAIL rd_arready got %b exp 1", arready);
    end
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({m_req_o, m_we_o, m_addr_o, m_sel_o, rvalid} !== {2'b10, 32'h2000_0000, 4'hF, 1'b0}) begin
        errors++; $display("FAIL rd_bus cycle %0d got %b %b %h %h %b exp 1 0 20000000 f 0",
                           i, m_req_o, m_we_o, m_addr_o, m_sel_o, rvalid);
      end
      if (i == 4) begin
        m_ack_i = 1'b1; m_data_i = 32'h1234_5678;
      end
      tick();
    end
    m_ack_i = 1'b0; m_data_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rvalid, rresp, rdata, m_req_o} !== {1'b1, 2'b00, 32'h1234_5678, 1'b0}) begin
        errors++; $display("FAIL rd_hold cycle %0d got %b %b %h %b exp 1 00 12345678 0",
                           i, rvalid, rresp, rdata, m_req_o);
      end
      if (i == 4) rready = 1'b1;
      tick();
    end
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_done got %b exp 0", rvalid);
    end
  endtask

  task automatic test_collision();
    m_ack_i = 1'b1; m_data_i = 32'h0BAD_F00D;
    awaddr = 32'h5000_0000; wdata = 32'h0000_CAFE; wstrb = 4'hF;
    araddr = 32'h4000_0000;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b110) begin
      errors++; $display("FAIL coll_ready got %b exp 110", {awready, wready, arready});
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({arready, m_req_o, m_we_o, m_addr_o} !== {3'b011, 32'h5000_0000}) begin
      errors++; $display("FAIL coll_write_first got %b %b %b %h exp 0 1 1 50000000", arready, m_req_o, m_we_o, m_addr_o);
    end
    tick();
    tick();
    checks++;
    if ({bvalid, arready} !== 2'b10) begin
      errors++; $display("FAIL coll_ar_blocked got %b exp 10", {bvalid, arready});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checks++;
    if ({bvalid, arready} !== 2'b01) begin
      errors++; $display("FAIL coll_ar_open got %b exp 01", {bvalid, arready});
    end
    tick();
    arvalid = 1'b0;
    checks++;
    if ({m_req_o, m_we_o, m_addr_o} !== {2'b10, 32'h4000_0000}) begin
      errors++; $display("FAIL coll_read_bus got %b %b %h exp 1 0 40000000", m_req_o, m_we_o, m_addr_o);
    end
    tick();
    checks++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h0BAD_F00D}) begin
      errors++; $display("FAIL coll_read_data got %b %b %h exp 1 00 0badf00d", rvalid, rresp, rdata);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_timeout();
    int waited;
    m_ack_i = 1'b0; m_data_i = 32'h5555_5555;
    araddr = 32'h6000_0000; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    waited = 0;
`ifdef AXIL_SLV_TIMEOUT_EN
    while (rvalid !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    checks++;
    if (waited !== 16) begin
      errors++; $display("FAIL to_latency got %0d exp 16", waited);
    end
    checks++;
    if ({rvalid, rresp, rdata, m_req_o} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin
      errors++; $display("FAIL to_slverr got %b %b %h %b exp 1 10 0 0", rvalid, rresp, rdata, m_req_o);
    end
`else
    while (rvalid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    checks++;
    if ({rvalid, m_req_o} !== 2'b01) begin
      errors++; $display("FAIL to_none_wait got %b after %0d cycles exp 01", {rvalid, m_req_o}, waited);
    end
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    checks++;
    if ({rvalid, rresp, rdata} !== {1'b1, 2'b00, 32'h5555_5555}) begin
      errors++; $display("FAIL to_none_late_ack got %b %b %h exp 1 00 55555555", rvalid, rresp, rdata);
    end
`endif
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_ack_i = 1'b0;
    araddr = 32'h7000_0000; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checks++;
    if (m_req_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_bus got %b exp 1", m_req_o);
    end
    areset = 1'b1;
    tick();
    checks++;
    if (all_outs() !== 115'd0) begin
      errors++; $display("FAIL rst_mid_outputs got %h exp 0", all_outs());
    end
    areset = 1'b0; m_ack_i = 1'b1; m_data_i = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rvalid, m_req_o, bvalid} !== 3'b000) begin
        errors++; $display("FAIL rst_mid_silent cycle %0d got %b exp 000", i, {rvalid, m_req_o, bvalid});
      end
    end
    awaddr = 32'h8000_0008; wdata = 32'h0102_0304; wstrb = 4'b1100;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({m_req_o, m_we_o, m_addr_o, m_data_o, m_sel_o} !== {2'b11, 32'h8000_0008, 32'h0102_0304, 4'b1100}) begin
      errors++; $display("FAIL rst_mid_write_bus got %b %b %h %h %b exp 1 1 80000008 01020304 1100",
                         m_req_o, m_we_o, m_addr_o, m_data_o, m_sel_o);
    end
    tick();
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin
      errors++; $display("FAIL rst_mid_write_resp got %b exp 100", {bvalid, bresp});
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    m_ack_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_simultaneous();
    test_w_before_aw();
    test_read_wait();
    test_collision();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axil_slave.md
AXIL_SLAVE -- requirements
Module: axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI-Lite data width (only 32 supported).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, bus-wait limit used only under AXIL_SLV_TIMEOUT_EN.
REQ-004 S_AXI_ACLK  input  1  the single clock; all logic on its rising edge.
REQ-005 S_AXI_ARESET  input  1  reset, synchronous, active-high.
REQ-006 S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWPROT in 3 (ignored), S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel.
REQ-007 S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-008 S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-009 S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARPROT in 3 (ignored), S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel.
REQ-010 S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-011 m_addr_o out 32, m_data_o out 32, m_sel_o out 4, m_we_o out 1, m_req_o out 1: RIB master request to peripheral.
REQ-012 m_data_i in 32, m_ack_i in 1: RIB read data and completion strobe from peripheral.

Function
REQ-013 SHALL implement FSM states IDLE, WR_BUS, WR_RESP, RD_BUS, RD_RESP; one outstanding transaction max.
REQ-014 IDLE: AWREADY=1 while AW not yet latched, WREADY=1 while W not yet latched; AW and W SHALL be latched independently, any order, any cycle gap.
REQ-015 IDLE -> WR_BUS on the cycle both AW and W are latched (including simultaneous handshake).
REQ-016 IDLE: ARREADY=1 only when neither AW nor W latched and AWVALID=0 and WVALID=0 (write priority on collision).
REQ-017 IDLE -> RD_BUS on ARVALID&&ARREADY; ARADDR latched.
REQ-018 WR_BUS: m_req_o=1, m_we_o=1, m_addr_o=latched AWADDR, m_data_o=latched WDATA, m_sel_o=latched WSTRB; stays until m_ack_i=1, then -> WR_RESP.
REQ-019 RD_BUS: m_req_o=1, m_we_o=0, m_addr_o=latched ARADDR, m_sel_o=4'hF; on m_ack_i=1 m_data_i SHALL be registered into RDATA, -> RD_RESP.
REQ-020 WR_RESP: BVALID=1, BRESP held stable until BREADY=1, then -> IDLE and AW/W latches cleared.
REQ-021 RD_RESP: RVALID=1, RDATA/RRESP held stable until RREADY=1, then -> IDLE.
REQ-022 Minimum latency with m_ack_i tied high: handshake cycle N, m_req_o at N+1, BVALID/RVALID at N+2.
REQ-023 m_req_o SHALL be 0 in every state other than WR_BUS/RD_BUS; m_ack_i outside those states SHALL be ignored.
REQ-024 BRESP/RRESP SHALL be 2'b00 (OKAY) except on timeout (REQ-029).
REQ-025 Addresses SHALL pass through unmodified; no decode inside this block.

Reset
REQ-026 On S_AXI_ARESET=1 at a clock edge: state=IDLE, AW/W latches cleared, all READY/VALID outputs 0 for that cycle, BRESP=RRESP=0, RDATA=0, m_req_o=0, m_we_o=0, m_addr_o=0, m_data_o=0, m_sel_o=0.
REQ-027 Reset mid-transaction SHALL abandon it silently: no BVALID/RVALID issued afterwards for it.

Configuration
REQ-028 Macro AXIL_SLV_TIMEOUT_EN SHALL enable a bus-wait counter, cleared on entry to WR_BUS/RD_BUS, incrementing each cycle without m_ack_i.
REQ-029 With it defined: counter reaching TIMEOUT_CYCLES without m_ack_i SHALL force exit to WR_RESP/RD_RESP with response 2'b10 (SLVERR), RDATA=0, m_req_o dropped; m_ack_i on that same cycle wins (OKAY).
REQ-030 Without it: no counter, WR_BUS/RD_BUS wait indefinitely, response always OKAY.

Verification
REQ-031 AW+W same cycle, AWADDR=0x1000_0004, WDATA=0xDEAD_BEEF, WSTRB=4'hF, m_ack_i=1 -> m_req_o/m_we_o 1 at N+1 with those values, BVALID at N+2, BRESP=00.
REQ-032 W 3 cycles before AW, WSTRB=4'b0011 -> no m_req_o until AW latched; m_sel_o=4'b0011; single BVALID.
REQ-033 Read 0x2000_0000, m_ack_i after 5 cycles with m_data_i=0x1234_5678, RREADY low 4 cycles -> RVALID held, RDATA=0x1234_5678 stable, RRESP=00.
REQ-034 AWVALID, WVALID, ARVALID all asserted in IDLE -> write served first, ARREADY=0 until BVALID&&BREADY, then read accepted.
REQ-035 AXIL_SLV_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_ack_i held 0 on read -> RVALID after 16 bus cycles, RRESP=10, RDATA=0; without macro RVALID never asserts.
REQ-036 S_AXI_ARESET pulsed during RD_BUS -> next cycle all outputs 0, no RVALID; subsequent write completes normally.
